// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encodings and default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait counter for a bus transaction; saturates at MAX_WAIT.
module mem_timeout_cnt #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    assign expired = (count == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store traffic,
// data having fixed priority; returns per-requester read data and a pipeline stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk_w_i,
    input  logic                rst_w_i_h,
    input  logic                if_req_w_i_h,
    input  logic [ADDR_W-1:0]   if_addr_w_i,
    output logic                if_valid_w_o_h,
    output logic [DATA_W-1:0]   if_rdata_w_o,
    input  logic                mem_rd_w_i_h,
    input  logic                mem_wr_w_i_h,
    input  logic [ADDR_W-1:0]   d_addr_w_i,
    input  logic [DATA_W-1:0]   d_wdata_w_i,
    input  logic [DATA_W/8-1:0] d_be_w_i,
    output logic                d_valid_w_o_h,
    output logic [DATA_W-1:0]   d_rdata_w_o,
    output logic                bus_req_w_o_h,
    output logic                bus_we_w_o_h,
    output logic [ADDR_W-1:0]   bus_addr_w_o,
    output logic [DATA_W-1:0]   bus_wdata_w_o,
    output logic [DATA_W/8-1:0] bus_be_w_o,
    input  logic                bus_ready_w_i_h,
    input  logic [DATA_W-1:0]   bus_rdata_w_i,
    output logic                stall_w_o_h,
    output logic                err_w_o_h
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_t       state, state_nxt;
    logic             busy;
    logic             d_req;
    logic             owner_d;
    logic             timeout;
    logic             cnt_expired;
    logic [CNT_W-1:0] wait_cnt;

    assign busy  = (state == ST_BUSY_I) || (state == ST_BUSY_D);
    assign d_req = mem_rd_w_i_h | mem_wr_w_i_h;

    // Abort on the edge that closes the MAX_WAIT-th unanswered BUSY cycle.
    assign timeout = busy && !bus_ready_w_i_h &&
                     (cnt_expired || (wait_cnt == CNT_W'(MAX_WAIT - 1)));

    mem_timeout_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_timeout (
        .clk     (clk_w_i),
        .rst     (rst_w_i_h),
        .clr     (state == ST_IDLE),
        .en      (busy && !bus_ready_w_i_h),
        .count   (wait_cnt),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (d_req) begin
                    state_nxt = ST_BUSY_D;
                end else if (if_req_w_i_h) begin
                    state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus_ready_w_i_h || timeout) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
        if (rst_w_i_h) begin
            bus_we_w_o_h  <= 1'b0;
            bus_addr_w_o  <= '0;
            bus_wdata_w_o <= '0;
            bus_be_w_o    <= '0;
            owner_d       <= 1'b0;
            if_rdata_w_o  <= '0;
            d_rdata_w_o   <= '0;
            err_w_o_h     <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (d_req) begin
                // A simultaneous rd/wr is resolved as a write and flagged.
                bus_we_w_o_h  <= mem_wr_w_i_h;
                bus_addr_w_o  <= d_addr_w_i;
                bus_wdata_w_o <= d_wdata_w_i;
                bus_be_w_o    <= d_be_w_i;
                owner_d       <= 1'b1;
                if (mem_rd_w_i_h && mem_wr_w_i_h) begin
                    err_w_o_h <= 1'b1;
                end
            end else if (if_req_w_i_h) begin
                bus_we_w_o_h <= 1'b0;
                bus_addr_w_o <= if_addr_w_i;
                bus_be_w_o   <= '1;
                owner_d      <= 1'b0;
            end
        end else if (busy) begin
            if (bus_ready_w_i_h) begin
                if (!owner_d) begin
                    if_rdata_w_o <= bus_rdata_w_i;
                end else if (!bus_we_w_o_h) begin
                    d_rdata_w_o <= bus_rdata_w_i;
                end
            end else if (timeout) begin
                err_w_o_h <= 1'b1;
                if (!owner_d) begin
                    if_rdata_w_o <= '0;
                end else if (!bus_we_w_o_h) begin
                    d_rdata_w_o <= '0;
                end
            end
        end
    end

    assign bus_req_w_o_h  = busy;
    assign if_valid_w_o_h = (state == ST_DONE) && !owner_d;
    assign d_valid_w_o_h  = (state == ST_DONE) && owner_d;
    assign stall_w_o_h    = ((state != ST_DONE) && (if_req_w_i_h || d_req)) || busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected valid responses are queued at issue
// time and a negedge monitor pops and compares them whenever a valid pulse appears.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        mem_rd, mem_wr;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        stall, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk_w_i         (clk),
        .rst_w_i_h       (rst),
        .if_req_w_i_h    (if_req),
        .if_addr_w_i     (if_addr),
        .if_valid_w_o_h  (if_valid),
        .if_rdata_w_o    (if_rdata),
        .mem_rd_w_i_h    (mem_rd),
        .mem_wr_w_i_h    (mem_wr),
        .d_addr_w_i      (d_addr),
        .d_wdata_w_i     (d_wdata),
        .d_be_w_i        (d_be),
        .d_valid_w_o_h   (d_valid),
        .d_rdata_w_o     (d_rdata),
        .bus_req_w_o_h   (bus_req),
        .bus_we_w_o_h    (bus_we),
        .bus_addr_w_o    (bus_addr),
        .bus_wdata_w_o   (bus_wdata),
        .bus_be_w_o      (bus_be),
        .bus_ready_w_i_h (bus_ready),
        .bus_rdata_w_i   (bus_rdata),
        .stall_w_o_h     (stall),
        .err_w_o_h       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if_valid || d_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got if_valid=%0b d_valid=%0b expected none (t=%0t)",
                         if_valid, d_valid, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_owner_d", {31'b0, d_valid}, {31'b0, e.is_d});
                chk("valid_owner_if", {31'b0, if_valid}, {31'b0, ~e.is_d});
                chk("valid_rdata", e.is_d ? d_rdata : if_rdata, e.data);
            end
        end
    end

    task automatic wait_bus();
        int n = 0;
        @(negedge clk);
        while (!bus_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("bus_req_rise", {31'b0, bus_req}, 32'd1);
    endtask

    // Called at the negedge of the first BUSY cycle; returns at the DONE negedge.
    task automatic serve(input int k, input logic [31:0] rd, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i <= k; i++) begin
            chk("busy_req", {31'b0, bus_req}, 32'd1);
            chk("busy_we", {31'b0, bus_we}, {31'b0, we});
            chk("busy_addr", bus_addr, a);
            chk("busy_be", {28'b0, bus_be}, {28'b0, be});
            if (we) chk("busy_wdata", bus_wdata, wd);
            chk("busy_stall", {31'b0, stall}, 32'd1);
            if (i == k) begin
                bus_ready = 1'b1;
                bus_rdata = rd;
            end
            @(negedge clk);
        end
        bus_ready = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        chk("done_req_low", {31'b0, bus_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; bus_ready = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_valids", {30'b0, if_valid, d_valid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: fetch, ready on first BUSY cycle
        if_req = 1; if_addr = 32'h100;
        push_exp(1'b0, 32'h0000_0013);
        wait_bus();
        if_req = 0;
        serve(0, 32'h0000_0013, 1'b0, 32'h100, 32'h0, 4'hF);
        chk("t1_stall_done", {31'b0, stall}, 32'd0);
        @(negedge clk);

        // 2: load and fetch together; load first, then fetch after an idle gap
        mem_rd = 1; d_addr = 32'h2000; d_be = 4'hF; if_req = 1; if_addr = 32'h104;
        push_exp(1'b1, 32'hDEAD_BEEF);
        push_exp(1'b0, 32'h0000_0093);
        wait_bus();
        mem_rd = 0;
        serve(3, 32'hDEAD_BEEF, 1'b0, 32'h2000, 32'h0, 4'hF);
        chk("t2_stall_done", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("t2_idle_gap", {31'b0, bus_req}, 32'd0);
        chk("t2_idle_stall", {31'b0, stall}, 32'd1);
        wait_bus();
        if_req = 0;
        serve(1, 32'h0000_0093, 1'b0, 32'h104, 32'h0, 4'hF);
        @(negedge clk);

        // 3: store; d_rdata keeps the previous load value
        mem_wr = 1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5; d_be = 4'b0011;
        push_exp(1'b1, 32'hDEAD_BEEF);
        wait_bus();
        mem_wr = 0; d_wdata = 32'h0;
        serve(2, 32'h1234_5678, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'b0011);
        chk("t3_err_clear", {31'b0, err}, 32'd0);
        @(negedge clk);

        // 4: fetch that never gets ready aborts after 15 BUSY cycles
        if_req = 1; if_addr = 32'h200;
        push_exp(1'b0, 32'h0);
        wait_bus();
        if_req = 0;
        n = 0;
        while (bus_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("t4_busy_cycles", n, 32'd15);
        chk("t4_err", {31'b0, err}, 32'd1);
        bus_ready = 1; bus_rdata = 32'h0BAD_0BAD;
        repeat (2) @(negedge clk);
        bus_ready = 0;
        repeat (2) @(negedge clk);
        chk("t4_err_sticky", {31'b0, err}, 32'd1);
        chk("t4_late_ready_ignored", if_rdata, 32'h0);

        rst = 1; @(negedge clk);
        chk("rst2_err", {31'b0, err}, 32'd0);
        rst = 0; @(negedge clk);

        // 5: rd and wr together -> write, err set
        mem_rd = 1; mem_wr = 1; d_addr = 32'h80; d_wdata = 32'h1122_3344; d_be = 4'hF;
        push_exp(1'b1, 32'h0);
        wait_bus();
        mem_rd = 0; mem_wr = 0;
        serve(0, 32'h5555_5555, 1'b1, 32'h80, 32'h1122_3344, 4'hF);
        chk("t5_err", {31'b0, err}, 32'd1);
        @(negedge clk);

        // 6: asynchronous reset in the middle of BUSY
        if_req = 1; if_addr = 32'h300;
        wait_bus();
        #2;
        if_req = 0;
        rst = 1;
        #1;
        chk("t6_async_bus_req", {31'b0, bus_req}, 32'd0);
        chk("t6_async_stall", {31'b0, stall}, 32'd0);
        chk("t6_async_valid", {30'b0, if_valid, d_valid}, 32'd0);
        chk("t6_async_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 0;
        bus_ready = 1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ready = 0;
        repeat (4) @(negedge clk);
        chk("t6_no_req_after", {31'b0, bus_req}, 32'd0);
        chk("t6_capture_dropped", if_rdata, 32'h0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
